// File: rtl/sync_frame_tx_1101.sv
// -----------------------------------------------------------------------------
// sync_frame_tx_1101
//
// Serial frame transmitter feeding a 1101 sequence detector, one bit per clock.
// A frame is: sync pattern 1101, DATA_W payload bits MSB-first, GAP_LEN zeros.
// With STUFF=1 a 0 is inserted after any "110" seen inside the payload so the
// detector can only match on the sync pattern.
//
// Ports:
//   clk    in   clock, all logic on rising edge
//   rst    in   synchronous active-high reset
//   start  in   frame request, sampled only while ready=1
//   data   in   payload, captured on the accepting edge
//   ready  out  1 while in IDLE (combinational from state)
//   o      out  registered serial bit
//   done   out  registered pulse during the final gap bit
//   pst    out  present state (IDLE=0, SYNC=1, DATA=2, GAP=3)
//   nxt    out  combinational next state (ignores rst)
//
// Handshake: a frame is accepted on a rising edge where ready=1 and start=1.
// There is no backpressure once accepted; start is ignored until ready returns.
//
// Timing: o is aligned with pst, i.e. while pst=SYNC the sync bits are on o,
// while pst=DATA the payload/stuff bits are on o, while pst=GAP the gap zeros
// are on o. The IDLE cycle between back-to-back frames also drives o=0.
// -----------------------------------------------------------------------------
module sync_frame_tx_1101 #(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 2,
  parameter int STUFF   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              o,
  output logic              done,
  output logic [1:0]        pst,
  output logic [1:0]        nxt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int DCW = $clog2(DATA_W + 1);
  localparam int GCW = $clog2(GAP_LEN + 1);
  localparam logic [3:0] SYNC_PAT = 4'b1101;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [1:0]        sync_cnt;   // index of the sync bit currently on o
  logic [DCW-1:0]    data_cnt;   // payload bits already placed on o
  logic [GCW-1:0]    gap_cnt;    // gap bits already placed on o
  logic [2:0]        hist;       // last three bits placed on o, newest in [0]

  logic last_data;
  logic last_gap;
  logic stuff_now;

  // The bit on o right now is the last payload bit once data_cnt hits DATA_W;
  // no stuffing is applied after it because the gap zeros break any pattern.
  assign last_data = (data_cnt == DCW'(DATA_W));
  assign last_gap  = (gap_cnt == GCW'(GAP_LEN));
  assign stuff_now = (STUFF != 0) && (hist == 3'b110) && !last_data;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)            state_nxt = SYNC;
      SYNC: if (sync_cnt == 2'd3) state_nxt = DATA;
      DATA: if (last_data)        state_nxt = GAP;
      GAP:  if (last_gap)         state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign pst   = state;
  assign nxt   = state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      o        <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
      sync_cnt <= '0;
      data_cnt <= '0;
      gap_cnt  <= '0;
      hist     <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          o        <= 1'b0;
          hist     <= 3'b000;
          sync_cnt <= '0;
          data_cnt <= '0;
          gap_cnt  <= '0;
          if (start) begin
            shreg <= data;
            o     <= 1'b1;        // first sync bit
            hist  <= 3'b001;
          end
        end

        SYNC: begin
          if (sync_cnt == 2'd3) begin
            // First payload bit; history ends in 1 here so no stuff is possible.
            o        <= shreg[DATA_W-1];
            hist     <= {hist[1:0], shreg[DATA_W-1]};
            shreg    <= shreg << 1;
            data_cnt <= DCW'(1);
          end else begin
            o        <= SYNC_PAT[2'd2 - sync_cnt];
            hist     <= {hist[1:0], SYNC_PAT[2'd2 - sync_cnt]};
            sync_cnt <= sync_cnt + 2'd1;
          end
        end

        DATA: begin
          if (last_data) begin
            o       <= 1'b0;
            hist    <= {hist[1:0], 1'b0};
            gap_cnt <= GCW'(1);
            done    <= (GAP_LEN == 1);
          end else if (stuff_now) begin
            // Stuffed zero: payload bit stays in place, count holds.
            o    <= 1'b0;
            hist <= {hist[1:0], 1'b0};
          end else begin
            o        <= shreg[DATA_W-1];
            hist     <= {hist[1:0], shreg[DATA_W-1]};
            shreg    <= shreg << 1;
            data_cnt <= data_cnt + DCW'(1);
          end
        end

        GAP: begin
          o <= 1'b0;
          if (last_gap) begin
            hist     <= 3'b000;
            data_cnt <= '0;
            gap_cnt  <= '0;
          end else begin
            hist    <= {hist[1:0], 1'b0};
            gap_cnt <= gap_cnt + GCW'(1);
            done    <= (gap_cnt == GCW'(GAP_LEN - 1));
          end
        end

        default: begin
          o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_frame_tx_1101.sv
// -----------------------------------------------------------------------------
// tb_sync_frame_tx_1101
//
// Drives two transmitters in parallel from the same inputs: u0 with STUFF=0 and
// u1 with STUFF=1 (DATA_W=8, GAP_LEN=2). Frame vectors carry hand-computed bit
// streams, frame lengths and expected hit counts of a non-overlapping 1101
// detector. Reset-mid-frame and back-to-back framing are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_sync_frame_tx_1101;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data;

  logic       ready0, o0, done0;
  logic [1:0] pst0, nxt0;
  logic       ready1, o1, done1;
  logic [1:0] pst1, nxt1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_frame_tx_1101 #(.DATA_W(8), .GAP_LEN(2), .STUFF(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .ready(ready0), .o(o0), .done(done0), .pst(pst0), .nxt(nxt0)
  );

  sync_frame_tx_1101 #(.DATA_W(8), .GAP_LEN(2), .STUFF(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .ready(ready1), .o(o1), .done(done1), .pst(pst1), .nxt(nxt1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Non-overlapping 1101 Mealy detector model, one per instance.
  int det_st[2];
  int hits[2];

  task automatic det_step(input int inst, input logic b);
    case (det_st[inst])
      0: det_st[inst] = b ? 1 : 0;
      1: det_st[inst] = b ? 2 : 0;
      2: det_st[inst] = b ? 2 : 3;
      default: begin
        if (b) hits[inst]++;
        det_st[inst] = 0;
      end
    endcase
  endtask

  // nxt must equal pst one edge later unless rst was applied at that edge.
  logic [1:0] prev_nxt0, prev_nxt1;
  bit         have_prev = 1'b0;
  logic       prev_rst  = 1'b1;

  always begin
    @(negedge clk);
    #2;
    if (have_prev && !prev_rst) begin
      check("nxt0_vs_pst0", 32'(pst0), 32'(prev_nxt0));
      check("nxt1_vs_pst1", 32'(pst1), 32'(prev_nxt1));
    end
    prev_nxt0 = nxt0;
    prev_nxt1 = nxt1;
    prev_rst  = rst;
    have_prev = 1'b1;
  end

  // ---------------- vectors ----------------
  // bitsN holds the frame right-aligned: the first bit on o is bitsN[lenN-1].
  typedef struct {
    logic [7:0]  data;
    logic [15:0] bits0;
    int          len0;
    int          hits0;
    logic [15:0] bits1;
    int          len1;
    int          hits1;
  } vec_t;

  vec_t vecs[6];
  vec_t vec_after_rst;

  // ---------------- driver tasks ----------------
  // Entered and left just after a falling edge with both instances idle.
  task automatic run_frame(input vec_t v);
    int maxlen;
    check("ready0_before", 32'(ready0), 32'd1);
    check("ready1_before", 32'(ready1), 32'd1);
    data  = v.data;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready0_drop", 32'(ready0), 32'd0);
    check("ready1_drop", 32'(ready1), 32'd0);
    for (int i = 0; i < 2; i++) begin
      det_st[i] = 0;
      hits[i]   = 0;
    end
    maxlen = (v.len0 > v.len1) ? v.len0 : v.len1;
    for (int k = 0; k <= maxlen; k++) begin
      for (int inst = 0; inst < 2; inst++) begin
        int          len;
        int          exp_hits;
        logic [15:0] bits;
        logic        act_o;
        logic        act_done;
        logic        act_ready;
        logic [1:0]  act_pst;
        logic [1:0]  exp_pst;
        len       = inst ? v.len1 : v.len0;
        bits      = inst ? v.bits1 : v.bits0;
        exp_hits  = inst ? v.hits1 : v.hits0;
        act_o     = inst ? o1 : o0;
        act_done  = inst ? done1 : done0;
        act_ready = inst ? ready1 : ready0;
        act_pst   = inst ? pst1 : pst0;
        if (k < len) begin
          if (k < 4)            exp_pst = 2'd1;
          else if (k < len - 2) exp_pst = 2'd2;
          else                  exp_pst = 2'd3;
          check($sformatf("d%02h_o%0d_bit%0d", v.data, inst, k), 32'(act_o), 32'(bits[len-1-k]));
          check($sformatf("d%02h_pst%0d_bit%0d", v.data, inst, k), 32'(act_pst), 32'(exp_pst));
          check($sformatf("d%02h_done%0d_bit%0d", v.data, inst, k), 32'(act_done), 32'(k == len - 1));
          det_step(inst, act_o);
        end else if (k == len) begin
          check($sformatf("d%02h_idle%0d", v.data, inst), 32'(act_pst), 32'd0);
          check($sformatf("d%02h_ready%0d_after", v.data, inst), 32'(act_ready), 32'd1);
          check($sformatf("d%02h_hits%0d", v.data, inst), 32'(hits[inst]), 32'(exp_hits));
        end
      end
      if (k < maxlen) @(negedge clk);
    end
  endtask

  // ---------------- test ----------------
  logic [14:0] b2b_pat;

  initial begin
    //             data   stream (STUFF=0)                        len hits  stream (STUFF=1)                              len hits
    vecs[0] = '{8'hA5, {2'b0, 4'b1101, 8'hA5, 2'b00}, 14, 1, {1'b0, 4'b1101, 9'b100100101, 2'b00}, 15, 1};
    vecs[1] = '{8'hD0, {2'b0, 4'b1101, 8'hD0, 2'b00}, 14, 2, {1'b0, 4'b1101, 9'b110010000, 2'b00}, 15, 1};
    vecs[2] = '{8'hFF, {2'b0, 4'b1101, 8'hFF, 2'b00}, 14, 1, {2'b0, 4'b1101, 8'hFF, 2'b00},        14, 1};
    vecs[3] = '{8'h00, {2'b0, 4'b1101, 8'h00, 2'b00}, 14, 1, {2'b0, 4'b1101, 8'h00, 2'b00},        14, 1};
    vecs[4] = '{8'h6D, {2'b0, 4'b1101, 8'h6D, 2'b00}, 14, 2, {4'b1101, 10'b0110011001, 2'b00},     16, 1};
    // Payload ends in 110: no stuff after the final payload bit.
    vecs[5] = '{8'h06, {2'b0, 4'b1101, 8'h06, 2'b00}, 14, 1, {2'b0, 4'b1101, 8'h06, 2'b00},        14, 1};
    vec_after_rst = '{8'h3C, {2'b0, 4'b1101, 8'h3C, 2'b00}, 14, 1, {1'b0, 4'b1101, 9'b001111000, 2'b00}, 15, 1};

    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pst0",   32'(pst0),   32'd0);
    check("rst_o0",     32'(o0),     32'd0);
    check("rst_done0",  32'(done0),  32'd0);
    check("rst_ready0", 32'(ready0), 32'd1);
    check("rst_pst1",   32'(pst1),   32'd0);
    check("rst_o1",     32'(o1),     32'd0);
    check("rst_done1",  32'(done1),  32'd0);
    check("rst_ready1", 32'(ready1), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Reset during the 6th bit of a frame abandons it.
    data  = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_pst0", 32'(pst0), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_pst0",  32'(pst0),  32'd0);
    check("midrst_o0",    32'(o0),    32'd0);
    check("midrst_done0", 32'(done0), 32'd0);
    check("midrst_pst1",  32'(pst1),  32'd0);
    check("midrst_o1",    32'(o1),    32'd0);
    check("midrst_done1", 32'(done1), 32'd0);
    @(negedge clk);
    check("midrst_still_idle0", 32'(pst0), 32'd0);
    run_frame(vec_after_rst);

    // start held high across three frames of zero payload: each frame is
    // 1101, eight payload zeros, two gap zeros, then one IDLE cycle.
    b2b_pat = 15'b110100000000000;
    data  = 8'h00;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 45; k++) begin
      if (k == 30) start = 1'b0;
      check($sformatf("b2b_o0_%0d", k),     32'(o0),     32'(b2b_pat[14 - (k % 15)]));
      check($sformatf("b2b_o1_%0d", k),     32'(o1),     32'(b2b_pat[14 - (k % 15)]));
      check($sformatf("b2b_ready0_%0d", k), 32'(ready0), 32'((k % 15) == 14));
      check($sformatf("b2b_done0_%0d", k),  32'(done0),  32'((k % 15) == 13));
      @(negedge clk);
    end
    check("b2b_no_fourth0", 32'(pst0), 32'd0);
    check("b2b_no_fourth1", 32'(pst1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
